// File: rtl/counter_monitor_pkg.sv
// Shared types and helpers for counter_monitor: FSM state encoding,
// expected-count prediction and saturating increment.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // All-ones mask for a field of the given width (1..32).
  function automatic logic [31:0] width_mask(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  // Value the upstream counter should present one cycle after prev_cnt/prev_en.
  function automatic logic [31:0] next_expected(input logic [31:0] prev_cnt,
                                                input logic        prev_en,
                                                input int          width);
    logic [31:0] nxt;
    nxt = prev_en ? (prev_cnt + 32'd1) : prev_cnt;
    return nxt & width_mask(width);
  endfunction

  // Increment that sticks at all-ones instead of rolling over.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int          width);
    return (value == width_mask(width)) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// Saturating statistic counter with synchronous clear.
module sat_counter
  import counter_monitor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_next;

  assign q_next = W'(sat_inc(32'(q), W));

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Cycle-accurate checker for an enable-driven up counter: predicts each sample,
// flags deviations, counts wraps and errors, latches a fault on repeated errors.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STAT_W    = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  cnt,
  input  logic              clear,
  output logic              wrap,
  output logic              mismatch,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic              fault,
  output logic              locked
);

  state_t           state;
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_en;
  logic [3:0]       run;

  logic [WIDTH-1:0] expected;
  logic [3:0]       run_inc;
  logic             cnt_mismatch;
  logic             wrap_hit;
  logic             track_active;
  logic             err_inc;
  logic             wrap_inc;

  assign expected     = WIDTH'(next_expected(32'(prev_cnt), prev_en, WIDTH));
  assign run_inc      = run + 4'd1;
  assign cnt_mismatch = (cnt != expected);
  assign wrap_hit     = prev_en && (prev_cnt == '1) && (cnt == '0);
  // clear overrides any compare result taken on the same edge
  assign track_active = (state == TRACK) && !clear;
  assign err_inc      = track_active && cnt_mismatch;
  assign wrap_inc     = track_active && !cnt_mismatch && wrap_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ACQUIRE;
      prev_cnt <= '0;
      prev_en  <= 1'b0;
      run      <= 4'd0;
      wrap     <= 1'b0;
      mismatch <= 1'b0;
      fault    <= 1'b0;
      locked   <= 1'b0;
    end else begin
      prev_cnt <= cnt;
      prev_en  <= enable;
      wrap     <= 1'b0;
      mismatch <= 1'b0;
      if (clear) begin
        state  <= ACQUIRE;
        run    <= 4'd0;
        fault  <= 1'b0;
        locked <= 1'b0;
      end else begin
        case (state)
          ACQUIRE: begin
            state  <= TRACK;
            locked <= 1'b1;
          end
          TRACK: begin
            if (cnt_mismatch) begin
              mismatch <= 1'b1;
              run      <= run_inc;
              if (run_inc == 4'(ERR_LIMIT)) begin
                state  <= FAULT;
                fault  <= 1'b1;
                locked <= 1'b0;
              end
            end else begin
              run  <= 4'd0;
              wrap <= wrap_hit;
            end
          end
          FAULT: begin
            fault  <= 1'b1;
            locked <= 1'b0;
          end
          default: begin
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .clr   (clear),
    .q     (wrap_cnt)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear),
    .q     (err_cnt)
  );

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor: directed scenarios plus a random
// segment, every edge compared against a behavioural model.
module tb_counter_monitor;

  localparam int MODV   = 16;
  localparam int SATMAX = 255;
  localparam int LIMIT  = 3;
  localparam int M_ACQ  = 0;
  localparam int M_TRK  = 1;
  localparam int M_FLT  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       clear = 1'b0;
  logic       wrap;
  logic       mismatch;
  logic [7:0] wrap_cnt;
  logic [7:0] err_cnt;
  logic       fault;
  logic       locked;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_prev = 0, m_pen = 0, m_mode = M_ACQ, m_run = 0;
  int m_wraps = 0, m_errs = 0, e_wrap = 0, e_mis = 0;

  counter_monitor #(.WIDTH(4), .STAT_W(8), .ERR_LIMIT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .cnt      (cnt),
    .clear    (clear),
    .wrap     (wrap),
    .mismatch (mismatch),
    .wrap_cnt (wrap_cnt),
    .err_cnt  (err_cnt),
    .fault    (fault),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_expect();
    return (m_pen != 0) ? (m_prev + 1) % MODV : m_prev;
  endfunction

  task automatic model_edge(input int rst_n, input int en, input int c, input int clr);
    int ev;
    e_wrap = 0;
    e_mis  = 0;
    if (rst_n == 0) begin
      m_prev = 0; m_pen = 0; m_mode = M_ACQ; m_run = 0; m_wraps = 0; m_errs = 0;
    end else begin
      ev = model_expect();
      if (clr != 0) begin
        m_mode = M_ACQ; m_run = 0; m_wraps = 0; m_errs = 0;
      end else if (m_mode == M_ACQ) begin
        m_mode = M_TRK;
      end else if (m_mode == M_TRK) begin
        if (c != ev) begin
          e_mis  = 1;
          m_errs = (m_errs < SATMAX) ? m_errs + 1 : SATMAX;
          m_run++;
          if (m_run == LIMIT) m_mode = M_FLT;
        end else begin
          m_run = 0;
          if (m_pen != 0 && m_prev == MODV - 1 && c == 0) begin
            e_wrap  = 1;
            m_wraps = (m_wraps < SATMAX) ? m_wraps + 1 : SATMAX;
          end
        end
      end
      m_prev = c;
      m_pen  = en;
    end
  endtask

  // One clock: apply inputs, model the edge, compare all outputs 1 time unit later.
  task automatic step(input int rst_n, input int en, input int c, input int clr, input int verbose);
    reset  = rst_n[0];
    enable = en[0];
    cnt    = 4'(c);
    clear  = clr[0];
    @(posedge clk);
    model_edge(rst_n, en, c, clr);
    #1;
    check("wrap",     wrap,     e_wrap);
    check("mismatch", mismatch, e_mis);
    check("wrap_cnt", wrap_cnt, m_wraps);
    check("err_cnt",  err_cnt,  m_errs);
    check("fault",    fault,    (m_mode == M_FLT) ? 1 : 0);
    check("locked",   locked,   (m_mode == M_TRK) ? 1 : 0);
    if (verbose != 0)
      $display("t=%0t rst=%0d en=%0d cnt=%0d clr=%0d -> wrap=%0d mis=%0d wc=%0d ec=%0d fault=%0d locked=%0d",
               $time, rst_n, en, c, clr, wrap, mismatch, wrap_cnt, err_cnt, fault, locked);
  endtask

  initial begin
    int c, en, clr, rst_n, r;

    // reset held low
    step(0, 0, 5, 0, 1);
    step(0, 1, 7, 0, 1);
    check("reset_locked", locked, 0);

    // free counting 0..15,0,1 with one wrap
    for (int i = 0; i < 18; i++) step(1, 1, i % 16, 0, 1);
    check("count_wrap_cnt", wrap_cnt, 1);
    check("count_err_cnt", err_cnt, 0);

    // held count under enable low is a match
    step(1, 1, 2, 0, 1);
    step(1, 1, 3, 0, 1);
    step(1, 0, 4, 0, 1);
    step(1, 0, 4, 0, 1);
    step(1, 1, 4, 0, 1);
    step(1, 1, 5, 0, 1);
    check("hold_err_cnt", err_cnt, 0);

    // single glitch 6 -> 9
    step(1, 1, 6, 0, 1);
    step(1, 1, 9, 0, 1);
    check("glitch_pulse", mismatch, 1);
    step(1, 1, 10, 0, 1);
    step(1, 1, 11, 0, 1);
    check("glitch_err_cnt", err_cnt, 1);
    check("glitch_fault", fault, 0);

    // three consecutive errors latch fault
    step(1, 1, 12, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 5, 0, 1);
    step(1, 1, 9, 0, 1);
    check("fault_set", fault, 1);
    check("fault_locked", locked, 0);
    for (int i = 10; i < 14; i++) step(1, 1, i, 0, 1);
    check("fault_err_hold", err_cnt, 4);

    // clear, then 300 wraps to saturate wrap_cnt
    step(1, 1, 14, 1, 1);
    for (int i = 0; i < 300 * 16; i++) step(1, 1, (15 + i) % 16, 0, 0);
    check("wrap_saturate", wrap_cnt, 255);
    $display("t=%0t saturation run done wrap_cnt=%0d err_cnt=%0d", $time, wrap_cnt, err_cnt);

    // clear together with a wrong count
    step(1, 1, 9, 1, 1);
    check("clear_wrap_cnt", wrap_cnt, 0);
    check("clear_no_mis", mismatch, 0);

    // fault again, then reset mid-count at cnt 9
    step(1, 1, 10, 0, 1);
    step(1, 1, 3, 0, 1);
    step(1, 1, 3, 0, 1);
    step(1, 1, 3, 0, 1);
    check("fault_again", fault, 1);
    step(0, 1, 9, 0, 1);
    check("reset_fault", fault, 0);
    for (int i = 0; i < 6; i++) step(1, 1, i, 0, 1);
    check("reacq_err_cnt", err_cnt, 0);

    // random: mostly correct counts with occasional glitches, clears, resets
    for (int i = 0; i < 600; i++) begin
      en    = int'($urandom_range(0, 3) != 0);
      r     = int'($urandom_range(0, 99));
      c     = (r < 12) ? int'($urandom_range(0, 15)) : model_expect();
      clr   = int'($urandom_range(0, 99) < 3);
      rst_n = int'($urandom_range(0, 199) != 0);
      step(rst_n, en, c, clr, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
